// File: rtl/key_pkg.sv
// Shared types and default constants for the pushbutton conditioning blocks.
// Holds the debounce FSM state encoding and board-level timing defaults.
// No logic; imported by key_sync and key_debounce_press.
package key_pkg;

  // Debounce FSM states: idle, qualifying a press, held, qualifying a release
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } key_state_t;

  // Board clock frequency; one second of hold time is the default long press
  localparam int CLK_HZ           = 50000000;
  // 100 us of stability at 50 MHz rejects typical contact bounce
  localparam int DEBOUNCE_DEFAULT = 5000;

endpackage

// File: rtl/key_sync.sv
// Metastability synchroniser for the raw key input: SYNC_STAGES flop chain.
// Latency: SYNC_STAGES cycles from key_n to ks.
// No backpressure; flops reset to 1 so a reset reads as "released".
module key_sync
  import key_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic ks
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw key into the bottom of the chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
  end

  // Chain registers; reset loads the released level
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign ks = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce_press.sv
// Debounces an active-low pushbutton into level, press/release and short/long pulses.
// Latency: press_pulse SYNC_STAGES+DEBOUNCE_CYCLES cycles after the key settles; release symmetric.
// No backpressure; all pulses are registered, single cycle. Option: KEY_PRESS_COUNT_EN adds press_count.
module key_debounce_press
  import key_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
  parameter int LONG_PRESS_CYCLES = CLK_HZ
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_n,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press
`ifdef KEY_PRESS_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  logic ks;

  key_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .key_n   (key_n),
    .ks      (ks)
  );

  key_state_t        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              key_level_q, key_level_d;
  logic              press_pulse_q, press_pulse_d;
  logic              release_pulse_q, release_pulse_d;
  logic              short_press_q, short_press_d;
  logic              long_press_q, long_press_d;
  logic              hold_run;
  logic              long_fire;

  // Next-state logic: debounce both edges, time the hold, form the event pulses
  always_comb begin
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    long_done_d     = long_done_q;
    key_level_d     = key_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    short_press_d   = 1'b0;
    long_press_d    = 1'b0;

    // Hold time keeps running while a release is still being qualified
    hold_run  = (state_q == PRESSED) || (state_q == DEB_RELEASE);
    long_fire = hold_run && (hold_cnt_q == HOLD_LAST);

    if (hold_run) begin
      if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      if (long_fire) begin
        long_press_d = 1'b1;
        long_done_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!ks) begin
          state_d   = DEB_PRESS;
          deb_cnt_d = DEB_ONE;
        end
      end
      DEB_PRESS: begin
        if (ks) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d       = PRESSED;
          key_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          hold_cnt_d    = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      PRESSED: begin
        if (ks) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = DEB_ONE;
        end
      end
      DEB_RELEASE: begin
        if (!ks) begin
          // Bounce during release: return to held, hold time preserved
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d         = IDLE;
          key_level_d     = 1'b0;
          release_pulse_d = 1'b1;
          // A long press firing on this very edge still counts as long
          short_press_d   = !(long_done_q || long_fire);
          long_done_d     = 1'b0;
        end else if (deb_cnt_q != DEB_MAX) begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, counters and registered outputs; reset overrides everything
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= IDLE;
      deb_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      long_done_q     <= 1'b0;
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      long_done_q     <= long_done_d;
      key_level_q     <= key_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      short_press_q   <= short_press_d;
      long_press_q    <= long_press_d;
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign short_press   = short_press_q;
  assign long_press    = long_press_q;

`ifdef KEY_PRESS_COUNT_EN
  logic [7:0] press_count_q, press_count_d;

  // Count accepted presses, advancing together with press_pulse; wraps at 256
  always_comb begin
    press_count_d = press_count_q;
    if (press_pulse_d) begin
      press_count_d = press_count_q + 8'd1;
    end
  end

  // Press counter register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      press_count_q <= 8'd0;
    end else begin
      press_count_q <= press_count_d;
    end
  end

  assign press_count = press_count_q;
`endif

endmodule

// File: tb/tb_key_debounce_press.sv
// Bench for key_debounce_press: event-level reference model feeds a scoreboard queue.
// A negedge monitor pops expected events whenever the DUT pulses and compares cycle and value.
// Directed scenarios plus randomized key activity; KEY_PRESS_COUNT_EN adds the press counter check.
module tb_key_debounce_press;

  localparam int S = 2;
  localparam int D = 8;
  localparam int L = 32;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  logic key_n    = 1'b1;
  logic key_level, press_pulse, release_pulse, short_press, long_press;
`ifdef KEY_PRESS_COUNT_EN
  logic [7:0] press_count;
`endif

  key_debounce_press #(
    .SYNC_STAGES      (S),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press)
`ifdef KEY_PRESS_COUNT_EN
    ,
    .press_count  (press_count)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected event: cycle it must appear in, pulses {press,release,short,long}, level
  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic       lvl;
  } ev_t;

  ev_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: key path as a delay line, debounce as a run length of
  // disagreeing samples, hold time as cycles since the accepted press.
  logic [S-1:0] m_sync  = '1;
  int           m_run   = 0;
  int           m_age   = 0;
  logic         m_level = 1'b0;
  logic         m_done  = 1'b0;
  int           m_presses = 0;

  // Statistics recorded by the monitor from what the DUT actually did
  int   n_press_seen = 0, n_release_seen = 0, n_long_seen = 0, n_ev_seen = 0;
  int   last_press_cyc = -1, last_release_cyc = -1, last_long_cyc = -1;
  logic last_release_short = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_step(input logic kn, input logic rst);
    logic       ks;
    logic [3:0] p;
    p = 4'b0000;
    if (rst) begin
      m_sync  = '1;
      m_run   = 0;
      m_age   = 0;
      m_level = 1'b0;
      m_done  = 1'b0;
      m_presses = 0;
    end else begin
      ks     = m_sync[S-1];
      m_sync = {m_sync[S-2:0], kn};
      if (m_level) begin
        m_age++;
        if (m_age == L) begin
          p[0]   = 1'b1;
          m_done = 1'b1;
        end
      end
      if ((!ks) != m_level) m_run++;
      else m_run = 0;
      if (m_run == D) begin
        m_run = 0;
        if (!m_level) begin
          p[3]    = 1'b1;
          m_level = 1'b1;
          m_age   = 0;
          m_presses++;
        end else begin
          p[2]    = 1'b1;
          p[1]    = !m_done;
          m_level = 1'b0;
          m_done  = 1'b0;
        end
      end
      if (p != 4'b0000) exp_q.push_back('{cyc: cyc + 1, p: p, lvl: m_level});
    end
  endtask

  // One clock of stimulus: drive, advance the model, step past the edge
  task automatic tick(input logic kn, input logic rst);
    key_n = kn;
    reset = rst;
    model_step(kn, rst);
    @(posedge CLOCK_50);
    cyc++;
    #1;
  endtask

  task automatic hold(input logic kn, input int n);
    for (int i = 0; i < n; i++) tick(kn, 1'b0);
  endtask

  // Monitor: flag overdue expectations, then match every DUT pulse to the queue
  always @(negedge CLOCK_50) begin
    logic [3:0] pulses;
    ev_t        e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_event: nothing seen, expected pulses %b at cycle %0d", e.p, e.cyc);
    end
    pulses = {press_pulse, release_pulse, short_press, long_press};
    if (pulses != 4'b0000) begin
      n_ev_seen++;
      if (press_pulse) begin n_press_seen++; last_press_cyc = cyc; end
      if (release_pulse) begin
        n_release_seen++;
        last_release_cyc   = cyc;
        last_release_short = short_press;
      end
      if (long_press) begin n_long_seen++; last_long_cyc = cyc; end
      if (exp_q.size() == 0) begin
        check("unexpected_event", int'(pulses), 0);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_pulses", int'(pulses), int'(e.p));
        check("event_level", int'(key_level), int'(e.lvl));
      end
    end
  end

  initial begin
    int f, r, rd, p0, rel0, l0, e0;
    logic kn;

    // Reset state
    repeat (3) tick(1'b1, 1'b1);
    check("reset_key_level", int'(key_level), 0);
    check("reset_press_pulse", int'(press_pulse), 0);
    check("reset_release_pulse", int'(release_pulse), 0);
    check("reset_short_press", int'(short_press), 0);
    check("reset_long_press", int'(long_press), 0);
`ifdef KEY_PRESS_COUNT_EN
    check("reset_press_count", int'(press_count), 0);
`endif
    hold(1'b1, 5);

    // Scenario 1: clean short press
    l0 = n_long_seen;
    f = cyc;
    hold(1'b0, 20);
    r = cyc;
    hold(1'b1, 15);
    check("s1_press_latency", last_press_cyc, f + 10);
    check("s1_release_latency", last_release_cyc, r + 10);
    check("s1_short_press", int'(last_release_short), 1);
    check("s1_no_long", n_long_seen, l0);

    // Scenario 2: bouncing press
    p0 = n_press_seen;
    hold(1'b0, 3);
    hold(1'b1, 2);
    f = cyc;
    hold(1'b0, 20);
    check("s2_single_press", n_press_seen, p0 + 1);
    check("s2_press_latency", last_press_cyc, f + 10);
    hold(1'b1, 15);

    // Scenario 3: long hold
    l0   = n_long_seen;
    rel0 = n_release_seen;
    hold(1'b0, 60);
    hold(1'b1, 15);
    check("s3_long_once", n_long_seen, l0 + 1);
    check("s3_long_latency", last_long_cyc, last_press_cyc + 32);
    check("s3_release_seen", n_release_seen, rel0 + 1);
    check("s3_short_suppressed", int'(last_release_short), 0);

    // Scenario 4: glitch shorter than the debounce window
    e0 = n_ev_seen;
    hold(1'b0, 7);
    hold(1'b1, 15);
    check("s4_no_events", n_ev_seen, e0);
    check("s4_level_low", int'(key_level), 0);

    // Scenario 5: reset while pressed, key still held
    f = cyc;
    hold(1'b0, 15);
    check("s5_level_before_reset", int'(key_level), 1);
    rel0 = n_release_seen;
    tick(1'b0, 1'b1);
    check("s5_level_after_reset", int'(key_level), 0);
    rd = cyc;
    hold(1'b0, 20);
    check("s5_no_release", n_release_seen, rel0);
    check("s5_repress_latency", last_press_cyc, rd + 10);
    hold(1'b1, 15);

    // Long press landing on the same edge as the accepted release
    rel0 = n_release_seen;
    f = cyc;
    hold(1'b0, 32);
    hold(1'b1, 20);
    check("edge_long_cycle", last_long_cyc, f + 42);
    check("edge_release_cycle", last_release_cyc, f + 42);
    check("edge_short_suppressed", int'(last_release_short), 0);

    // Randomized key activity with occasional resets
    kn = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 24));
      if (sel == 0) begin
        tick(kn, 1'b1);
      end else begin
        kn = ~kn;
        if (sel < 4) hold(kn, int'($urandom_range(35, 50)));
        else hold(kn, int'($urandom_range(1, 12)));
      end
    end
    hold(1'b1, 60);

`ifdef KEY_PRESS_COUNT_EN
    // Scenario 6: 257 presses wrap the counter to 1
    tick(1'b1, 1'b1);
    hold(1'b1, 4);
    for (int i = 0; i < 257; i++) begin
      hold(1'b0, 12);
      hold(1'b1, 12);
    end
    hold(1'b1, 10);
    check("s6_press_count", int'(press_count), 1);
    check("s6_press_count_model", int'(press_count), m_presses % 256);
`endif

    hold(1'b1, 5);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
